// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall responder: service codes, FSM states,
// decimal power table and ASCII constants.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

  typedef enum logic [3:0] {
    IDLE,
    CHAR_EMIT,
    INT_SIGN,
    INT_DIG,
    STR_REQ,
    STR_EMIT,
    HEX_EMIT,
    DONE,
    HALTED
  } state_t;

  // Index k holds 10^k, so the table reads 10^9 down to 10^0 left to right.
  localparam logic [9:0][31:0] POW10 = {
    32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
    32'd10000, 32'd1000, 32'd100, 32'd10, 32'd1
  };

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_A     = 8'h41;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
    else             return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/syscall_itoa.sv
// Decimal digit extractor: converts an unsigned 32-bit magnitude into
// decimal digits, most significant first, one digit per handshake.
// Extraction starts at the highest power not exceeding the magnitude, so
// leading zeros never appear and a single-digit value is ready at once.
module syscall_itoa
  import syscall_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mag,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic [3:0]  digit,
  output logic        last
);

  logic [31:0] rem;
  logic [3:0]  idx;
  logic [3:0]  dig;
  logic        busy;
  logic [3:0]  start_idx;
  logic [31:0] pow;
  logic        final_dig;

  // Pick the first power to walk: the largest 10^k not above the magnitude.
  always_comb begin
    start_idx = 4'd0;
    for (int k = 1; k < 10; k++)
      if (mag >= POW10[k]) start_idx = 4'(k);
  end

  assign pow         = POW10[idx];
  // At 10^0 the remainder is already the last digit.
  assign final_dig   = (idx == 4'd0) || (rem < pow);
  assign digit_valid = busy && final_dig;
  assign last        = (idx == 4'd0);
  assign digit       = (idx == 4'd0) ? rem[3:0] : dig;

  // Repeated subtraction per power; advance to the next power on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      rem  <= '0;
      idx  <= '0;
      dig  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rem  <= mag;
      idx  <= start_idx;
      dig  <= '0;
    end else if (busy) begin
      if (!final_dig) begin
        rem <= rem - pow;
        dig <= dig + 4'd1;
      end else if (digit_ready) begin
        dig <= '0;
        if (idx == 4'd0) busy <= 1'b0;
        else             idx  <= idx - 4'd1;
      end
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// Syscall responder beside EX/MEM: stalls the pipeline while servicing
// print-int, print-string, print-char and exit requests over a console
// valid/ready port and a byte-wide memory read port.
// Optional: define SYSCALL_HEX_EN to enable the print-hex service (code 34).
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int STR_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_valid,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        halt,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  state_t             state_q, state_d;
  logic [31:0]        a0_q;
  logic [7:0]         byte_q;
  logic [31:0]        cnt_q;
  logic               accept;
  logic signed [31:0] a0_s;
  logic               a0_neg;
  logic [31:0]        mag;
  logic               itoa_start, itoa_valid, itoa_ready, itoa_last;
  logic [3:0]         itoa_digit;
  logic [4:0]         hex_sh;
  logic [3:0]         hex_nib;

  assign accept     = (state_q == IDLE) && syscall_valid;
  assign a0_s       = a0;
  assign a0_neg     = a0_s < 0;
  // Negating the most negative value wraps to 0x80000000, the right magnitude.
  assign mag        = a0_neg ? 32'(-a0_s) : a0;
  assign itoa_start = accept && (v0 == SYS_PRINT_INT);
  assign itoa_ready = (state_q == INT_DIG) && out_ready;
  // Hex positions 2..9 select nibbles 7..0 of the captured argument.
  assign hex_sh     = 5'(6'd36 - {cnt_q[3:0], 2'b00});
  assign hex_nib    = 4'(a0_q >> hex_sh);

  syscall_itoa u_itoa (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (itoa_start),
    .mag         (mag),
    .digit_valid (itoa_valid),
    .digit_ready (itoa_ready),
    .digit       (itoa_digit),
    .last        (itoa_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b1;
    halt      = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    case (state_q)
      IDLE: begin
        stall = syscall_valid;
        if (syscall_valid) begin
          case (v0)
            SYS_PRINT_INT:  state_d = a0_neg ? INT_SIGN : INT_DIG;
            SYS_PRINT_STR:  state_d = (STR_MAX == 0) ? DONE : STR_REQ;
            SYS_EXIT:       state_d = HALTED;
            SYS_PRINT_CHAR: state_d = CHAR_EMIT;
`ifdef SYSCALL_HEX_EN
            SYS_PRINT_HEX:  state_d = HEX_EMIT;
`endif
            default:        state_d = DONE;
          endcase
        end
      end
      CHAR_EMIT: begin
        out_valid = 1'b1;
        out_data  = byte_q;
        if (out_ready) state_d = DONE;
      end
      INT_SIGN: begin
        out_valid = 1'b1;
        out_data  = ASCII_MINUS;
        if (out_ready) state_d = INT_DIG;
      end
      INT_DIG: begin
        // Digits go straight from the extractor to the console.
        out_valid = itoa_valid;
        out_data  = itoa_valid ? (ASCII_ZERO + {4'h0, itoa_digit}) : 8'h00;
        if (itoa_valid && out_ready && itoa_last) state_d = DONE;
      end
      STR_REQ: begin
        mem_req  = 1'b1;
        mem_addr = a0_q + cnt_q;
        if (mem_ack) state_d = (mem_rdata == 8'h00) ? DONE : STR_EMIT;
      end
      STR_EMIT: begin
        out_valid = 1'b1;
        out_data  = byte_q;
        if (out_ready) state_d = (cnt_q + 32'd1 == 32'(STR_MAX)) ? DONE : STR_REQ;
      end
      HEX_EMIT: begin
        out_valid = 1'b1;
        if (cnt_q == 32'd0)      out_data = ASCII_ZERO;
        else if (cnt_q == 32'd1) out_data = ASCII_X;
        else                     out_data = hex_ascii(hex_nib);
        if (out_ready && cnt_q == 32'd9) state_d = DONE;
      end
      DONE: begin
        // One free cycle lets the pipeline move past this SYSCALL.
        stall   = 1'b0;
        state_d = IDLE;
      end
      HALTED: halt = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, string byte latch and position counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q   <= '0;
      byte_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      a0_q   <= a0;
      byte_q <= a0[7:0];
      cnt_q  <= '0;
    end else if (state_q == STR_REQ && mem_ack) begin
      byte_q <= mem_rdata;
    end else if ((state_q == STR_EMIT || state_q == HEX_EMIT) && out_ready) begin
      cnt_q  <= cnt_q + 32'd1;
    end
  end

endmodule
